// File: rtl/fetch_prefetch_queue.sv
// Fetch stage with a DEPTH-entry prefetch queue. It owns the PC and issues in-order
// instruction-memory requests. Returned instructions are queued with their PCs until decode
// consumes them. A redirect flushes the queue, and any responses still in flight are discarded.
module fetch_prefetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     ILEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  input  logic            out_ready
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  pc_q    [DEPTH];
  logic [ILEN-1:0]  instr_q [DEPTH];
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [PtrW-1:0]  head_q, head_d;   // oldest entry, popped by decode
  logic [PtrW-1:0]  tail_q, tail_d;   // next slot to allocate on accept
  logic [PtrW-1:0]  fill_q, fill_d;   // oldest slot still waiting for its response
  logic [CntW-1:0]  alloc_cnt_q, alloc_cnt_d;
  logic [CntW-1:0]  pend_cnt_q, pend_cnt_d;
  logic [CntW-1:0]  drop_cnt_q, drop_cnt_d;

  logic            accept;
  logic            pop;
  logic            rsp_fill;
  logic            rsp_drop;
  logic [CntW-1:0] outstanding;

  // Handshake decode. Reset gates the valids so nothing is offered while rst is low.
  always_comb begin
    imem_req_valid = rst && !redirect_valid && (alloc_cnt_q < DepthCnt) && (drop_cnt_q == '0);
    imem_req_addr  = fetch_pc_q;
    accept         = imem_req_valid && imem_req_ready;
    out_valid      = rst && !redirect_valid && filled_q[head_q];
    out_instr      = instr_q[head_q];
    out_pc         = pc_q[head_q];
    pop            = out_valid && out_ready;
    rsp_drop       = imem_rsp_valid && (drop_cnt_q != '0);
    rsp_fill       = imem_rsp_valid && (drop_cnt_q == '0) && (pend_cnt_q != '0) &&
                     !redirect_valid;
    outstanding    = pend_cnt_q + drop_cnt_q;
  end

  // Next-state for the PC, pointers and counters; redirect overrides everything else.
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    head_d      = head_q;
    tail_d      = tail_q;
    fill_d      = fill_q;
    alloc_cnt_d = alloc_cnt_q;
    pend_cnt_d  = pend_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    filled_d    = filled_q;
    if (redirect_valid) begin
      fetch_pc_d  = {redirect_pc[XLEN-1:2], 2'b00};
      head_d      = '0;
      tail_d      = '0;
      fill_d      = '0;
      alloc_cnt_d = '0;
      pend_cnt_d  = '0;
      filled_d    = '0;
      // A response landing this cycle is one of the outstanding ones and is already gone.
      drop_cnt_d  = outstanding - CntW'(imem_rsp_valid && (outstanding != '0));
    end else begin
      if (accept) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
        tail_d     = tail_q + PtrW'(1);
      end
      if (pop) begin
        head_d           = head_q + PtrW'(1);
        filled_d[head_q] = 1'b0;
      end
      if (rsp_drop) begin
        drop_cnt_d = drop_cnt_q - CntW'(1);
      end
      if (rsp_fill) begin
        fill_d           = fill_q + PtrW'(1);
        filled_d[fill_q] = 1'b1;
      end
      alloc_cnt_d = alloc_cnt_q + CntW'(accept) - CntW'(pop);
      pend_cnt_d  = pend_cnt_q + CntW'(accept) - CntW'(rsp_fill);
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q  <= RESET_PC;
      head_q      <= '0;
      tail_q      <= '0;
      fill_q      <= '0;
      alloc_cnt_q <= '0;
      pend_cnt_q  <= '0;
      drop_cnt_q  <= '0;
      filled_q    <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      fill_q      <= fill_d;
      alloc_cnt_q <= alloc_cnt_d;
      pend_cnt_q  <= pend_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      filled_q    <= filled_d;
    end
  end

  // Queue payload: the PC is captured at allocation, the instruction at fill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
    end else begin
      if (accept) begin
        pc_q[tail_q] <= fetch_pc_q;
      end
      if (rsp_fill) begin
        instr_q[fill_q] <= imem_rsp_data;
      end
    end
  end

  // A response with nothing outstanding breaks the memory protocol.
  rsp_has_owner_a: assert property (@(posedge clk) disable iff (!rst)
    imem_rsp_valid |-> (outstanding != '0));

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue. The memory responder answers the accepted addresses
// in order while rsp_en is set. Expected values are written per step.
module tb_fetch_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;

  fetch_prefetch_queue #(
    .XLEN    (32),
    .ILEN    (32),
    .DEPTH   (4),
    .RESET_PC(32'h100)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr (imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_ready     (out_ready)
  );

  always #5 clk = ~clk;

  int          n_err = 0;
  int          n_chk = 0;
  logic [31:0] mq[$];
  logic        rsp_en;
  logic        acc, pop, ov;
  logic [31:0] acc_addr, pop_pc, pop_instr;
  int          n_acc;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // One cycle, entered and left at a falling edge. The response is driven first, then the
  // settled handshakes are sampled.
  task automatic cyc();
    if (rsp_en && mq.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(mq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
    acc       = imem_req_valid && imem_req_ready;
    acc_addr  = imem_req_addr;
    ov        = out_valid;
    pop       = out_valid && out_ready;
    pop_pc    = out_pc;
    pop_instr = out_instr;
    if (acc) mq.push_back(imem_req_addr);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    rsp_en         = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    mq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;
    do_reset();
    rst = 1'b0;
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_req_addr", imem_req_addr, 32'h100);
    @(negedge clk);
    rst = 1'b1;

    // 1: sustained stream with 1-cycle response latency.
    rsp_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("t1_acc", acc, 1);
      chk("t1_addr", acc_addr, 32'h100 + 32'(4 * i));
      if (i >= 2) begin
        chk("t1_pop", pop, 1);
        chk("t1_pc", pop_pc, 32'h100 + 32'(4 * (i - 2)));
        chk("t1_instr", pop_instr, instr_of(32'h100 + 32'(4 * (i - 2))));
      end else begin
        chk("t1_nopop", pop, 0);
      end
    end

    // 2: decode stalled, the queue fills to DEPTH, then drains in order.
    do_reset();
    rsp_en    = 1'b1;
    out_ready = 1'b0;
    n_acc     = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      n_acc += int'(acc);
    end
    chk("t2_acc_count", n_acc, 4);
    chk("t2_full_req", imem_req_valid, 0);
    chk("t2_full_ov", out_valid, 1);
    out_ready = 1'b1;
    cyc();
    chk("t2_r0_pc", pop_pc, 32'h100);
    chk("t2_r0_noacc", acc, 0);
    cyc();
    chk("t2_r1_pc", pop_pc, 32'h104);
    chk("t2_r1_acc", acc, 1);
    chk("t2_r1_addr", acc_addr, 32'h110);
    cyc();
    chk("t2_r2_pc", pop_pc, 32'h108);
    cyc();
    chk("t2_r3_pop", pop, 1);
    chk("t2_r3_pc", pop_pc, 32'h10C);
    cyc();
    chk("t2_r4_pc", pop_pc, 32'h110);

    // 3: redirect with two responses outstanding; both are dropped before 0x200 is requested.
    do_reset();
    out_ready = 1'b1;
    cyc();
    cyc();
    chk("t3_acc1", acc_addr, 32'h104);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    cyc();
    chk("t3_redir_noacc", acc, 0);
    redirect_valid = 1'b0;
    rsp_en         = 1'b1;
    cyc();
    chk("t3_drop2_noacc", acc, 0);
    chk("t3_drop2_nopop", pop, 0);
    cyc();
    chk("t3_drop1_noacc", acc, 0);
    chk("t3_drop1_nopop", pop, 0);
    cyc();
    chk("t3_acc", acc, 1);
    chk("t3_addr", acc_addr, 32'h200);
    cyc();
    chk("t3_nopop", pop, 0);
    cyc();
    chk("t3_pop", pop, 1);
    chk("t3_pc", pop_pc, 32'h200);
    chk("t3_instr", pop_instr, instr_of(32'h200));

    // 4: redirect in the same cycle as a response while decode is ready.
    do_reset();
    rsp_en    = 1'b1;
    out_ready = 1'b0;
    cyc();
    cyc();
    cyc();
    chk("t4_head_valid", ov, 1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    out_ready      = 1'b1;
    cyc();
    chk("t4_redir_ov", ov, 0);
    chk("t4_redir_noacc", acc, 0);
    redirect_valid = 1'b0;
    cyc();
    chk("t4_acc", acc, 1);
    chk("t4_addr", acc_addr, 32'h300);
    chk("t4_nopop", pop, 0);
    cyc();
    chk("t4_nopop2", pop, 0);
    cyc();
    chk("t4_pop", pop, 1);
    chk("t4_pc", pop_pc, 32'h300);

    // 5: PC wraps past 0xFFFFFFFC.
    do_reset();
    rsp_en         = 1'b1;
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    cyc();
    redirect_valid = 1'b0;
    cyc();
    chk("t5_addr0", acc_addr, 32'hFFFF_FFF8);
    cyc();
    chk("t5_addr1", acc_addr, 32'hFFFF_FFFC);
    cyc();
    chk("t5_wrap_acc", acc, 1);
    chk("t5_wrap_addr", acc_addr, 32'h0);
    chk("t5_pc0", pop_pc, 32'hFFFF_FFF8);
    cyc();
    chk("t5_pc1", pop_pc, 32'hFFFF_FFFC);
    cyc();
    chk("t5_pop2", pop, 1);
    chk("t5_pc2", pop_pc, 32'h0);

    // 6: asynchronous reset mid-stream with a response still outstanding.
    do_reset();
    rsp_en    = 1'b1;
    out_ready = 1'b0;
    repeat (4) cyc();
    chk("t6_pre_pc", out_pc, 32'h100);
    #3;
    rst = 1'b0;
    #1;
    chk("t6_req_valid", imem_req_valid, 0);
    chk("t6_out_valid", out_valid, 0);
    chk("t6_out_pc", out_pc, 0);
    chk("t6_out_instr", out_instr, 0);
    chk("t6_req_addr", imem_req_addr, 32'h100);
    mq.delete();
    imem_rsp_valid = 1'b0;
    out_ready      = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    cyc();
    chk("t6_restart_addr", acc_addr, 32'h100);
    cyc();
    cyc();
    chk("t6_pop", pop, 1);
    chk("t6_pc", pop_pc, 32'h100);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
